sram_word_arbiter: RTL and testbench

//  Two-requester round-robin arbiter and sequencer for one 512x32 word bank.
//  The bank is four 512x8 byte macros sharing CEN/GWEN/A, with a split D/Q/WEN.

---
 rtl/sram_word_arbiter_pkg.sv | 13 +
 rtl/sram_word_arbiter_if.sv | 27 ++
 rtl/sram_word_arbiter_rr_arb2.sv | 34 +++
 rtl/sram_word_arbiter.sv | 84 ++++++++
 tb/tb_sram_word_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/sram_word_arbiter_pkg.sv
// rtl/sram_word_arbiter_pkg.sv - shared widths and tag types for the SRAM word bank
package kianv_sram_pkg;
  localparam int SRAM_ADDR_W = 9;
  localparam int SRAM_DATA_W = 32;
  localparam int SRAM_NBYTES = SRAM_DATA_W / 8;

  typedef logic req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;
endpackage

// File: rtl/sram_word_arbiter_if.sv
// rtl/sram_word_arbiter_if.sv - two-requester word request/response bundle
interface sram_word_arbiter_if
  import kianv_sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
);
  localparam int NBYTES = DATA_W / 8;

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [2*NBYTES-1:0] req_wstrb;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_addr, req_wdata, req_wstrb,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wstrb,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_word_arbiter_rr_arb2.sv
// rtl/sram_word_arbiter_rr_arb2.sv - two-way round-robin grant with preference pointer
module rr_arb2
  import kianv_sram_pkg::*;
(
  input  logic    clk,
  input  logic    resetn,
  input  logic [1:0] req,
  output logic [1:0] grant,
  output req_id_t grant_id
);
  // ptr = 0 prefers requester 0, ptr = 1 prefers requester 1
  logic ptr;

  always_comb begin
    grant = 2'b00;
    if (resetn) begin
      case (req)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = ptr ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
    grant_id = grant[1];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr <= 1'b0;
    end else if (|grant) begin
      ptr <= grant[0];
    end
  end
endmodule

// File: rtl/sram_word_arbiter.sv
// rtl/sram_word_arbiter.sv - round-robin sequencer from word requests to active-low SRAM macro commands
module sram_word_arbiter
  import kianv_sram_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
)(
  input  logic              clk,
  input  logic              resetn,
  sram_word_arbiter_if.slave bus,
  output logic              sram_cen,
  output logic              sram_gwen,
  output logic [DATA_W-1:0] sram_wen,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);
  localparam int NBYTES = DATA_W / 8;

  logic [1:0]        grant;
  req_id_t           grant_id;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [NBYTES-1:0] sel_wstrb;
  logic [DATA_W-1:0] sel_wen;
  tag_t              tag1;
  tag_t              tag2;

  rr_arb2 u_arb (
    .clk      (clk),
    .resetn   (resetn),
    .req      (bus.req_valid),
    .grant    (grant),
    .grant_id (grant_id)
  );

  assign bus.req_ready = grant;

  always_comb begin
    sel_addr  = grant_id ? bus.req_addr[2*ADDR_W-1:ADDR_W]  : bus.req_addr[ADDR_W-1:0];
    sel_wdata = grant_id ? bus.req_wdata[2*DATA_W-1:DATA_W] : bus.req_wdata[DATA_W-1:0];
    sel_wstrb = grant_id ? bus.req_wstrb[2*NBYTES-1:NBYTES] : bus.req_wstrb[NBYTES-1:0];
    sel_wen   = '1;
    for (int b = 0; b < NBYTES; b++) begin
      sel_wen[8*b +: 8] = {8{~sel_wstrb[b]}};
    end
  end

  // Address and data hold through idle cycles so the macro inputs do not toggle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sram_cen  <= 1'b1;
      sram_gwen <= 1'b1;
      sram_wen  <= '1;
      sram_a    <= '0;
      sram_d    <= '0;
      tag1      <= '0;
      tag2      <= '0;
    end else begin
      tag1 <= '{valid: |grant, id: grant_id};
      tag2 <= tag1;
      if (|grant) begin
        sram_cen  <= 1'b0;
        sram_gwen <= ~|sel_wstrb;
        sram_wen  <= sel_wen;
        sram_a    <= sel_addr;
        sram_d    <= sel_wdata;
      end else begin
        sram_cen  <= 1'b1;
        sram_gwen <= 1'b1;
        sram_wen  <= '1;
      end
    end
  end

  // Macro output is already registered, so read data is passed straight through.
  always_comb begin
    bus.rsp_valid = 2'b00;
    if (tag2.valid) begin
      bus.rsp_valid[tag2.id] = 1'b1;
    end
    bus.rsp_rdata = sram_q;
  end
endmodule

// File: tb/tb_sram_word_arbiter.sv
// tb/tb_sram_word_arbiter.sv - scoreboard bench for sram_word_arbiter with a behavioural macro
module tb_sram_word_arbiter;
  import kianv_sram_pkg::*;

  localparam int AW = SRAM_ADDR_W;
  localparam int DW = SRAM_DATA_W;
  localparam int NB = SRAM_NBYTES;

  typedef struct {
    int          id;
    bit          chk;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn;
  logic          v0, v1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;
  logic [NB-1:0] s0, s1;
  logic          sram_cen, sram_gwen;
  logic [DW-1:0] sram_wen, sram_d, sram_q;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] mem [512];

  exp_t sb[$];
  int   grant_log[$];
  int   acc_log[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] pat [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_word_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  assign bus.req_valid = {v1, v0};
  assign bus.req_addr  = {a1, a0};
  assign bus.req_wdata = {d1, d0};
  assign bus.req_wstrb = {s1, s0};

  sram_word_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .sram_cen  (sram_cen),
    .sram_gwen (sram_gwen),
    .sram_wen  (sram_wen),
    .sram_a    (sram_a),
    .sram_d    (sram_d),
    .sram_q    (sram_q)
  );

  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) begin
        for (int i = 0; i < DW; i++) begin
          if (!sram_wen[i]) mem[sram_a][i] <= sram_d[i];
        end
      end
      sram_q <= mem[sram_a];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (cyc > 0 && bus.rsp_valid != 2'b00) begin
      check("rsp_not_both", {31'b0, bus.rsp_valid != 2'b11}, 32'd1);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL rsp_unexpected: got rsp_valid %b expected none (cycle %0d)", bus.rsp_valid, cyc);
      end else begin
        e = sb.pop_front();
        check("rsp_id", {30'b0, bus.rsp_valid}, (e.id == 1) ? 32'd2 : 32'd1);
        check("rsp_cycle", cyc, e.due);
        if (e.chk) check("rsp_rdata", bus.rsp_rdata, e.data);
      end
    end
  end

  task automatic xfer(input int id, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                      input logic [NB-1:0] st, input logic [31:0] exp);
    bit done = 0;
    if (id == 0) begin v0 = 1; a0 = addr; d0 = wd; s0 = st; end
    else         begin v1 = 1; a1 = addr; d1 = wd; s1 = st; end
    for (int t = 0; t < 20 && !done; t++) begin
      @(negedge clk);
      if (bus.req_ready[id]) begin
        sb.push_back('{id, (st == 0), exp, cyc + 2});
        grant_log.push_back(id);
        acc_log.push_back(cyc);
        done = 1;
        @(posedge clk);
        #1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: requester %0d got no ready expected ready within 20 cycles", id);
      if (id == 0) v0 = 0; else v1 = 0;
    end
  endtask

  task automatic idle(input int n);
    v0 = 0;
    v1 = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    pat[0] = 32'h0123_4567;
    pat[1] = 32'h89AB_CDEF;
    pat[2] = 32'h5A5A_A5A5;
    pat[3] = 32'hC3C3_3C3C;
    resetn = 0;
    v0 = 0; v1 = 0; a0 = '0; a1 = '0; d0 = '0; d1 = '0; s0 = '0; s1 = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_cen", {31'b0, sram_cen}, 32'd1);
      check("idle_gwen", {31'b0, sram_gwen}, 32'd1);
      check("idle_wen", sram_wen, 32'hFFFF_FFFF);
      check("idle_rsp", {30'b0, bus.rsp_valid}, 32'd0);
    end
    @(posedge clk);
    #1;

    xfer(0, 9'h1A5, 32'hDEAD_BEEF, 4'hF, 32'h0);
    check("issue_cen", {31'b0, sram_cen}, 32'd0);
    check("issue_gwen", {31'b0, sram_gwen}, 32'd0);
    check("issue_a", {23'b0, sram_a}, 32'h1A5);
    check("issue_d", sram_d, 32'hDEAD_BEEF);
    xfer(0, 9'h1A5, 32'h0, 4'h0, 32'hDEAD_BEEF);
    idle(4);

    xfer(0, 9'h0A5, 32'h1122_3344, 4'hF, 32'h0);
    xfer(0, 9'h0A5, 32'hAABB_CCDD, 4'h5, 32'h0);
    check("strobe_wen", sram_wen, 32'hFF00_FF00);
    check("strobe_gwen", {31'b0, sram_gwen}, 32'd0);
    xfer(0, 9'h0A5, 32'h0, 4'h0, 32'h11BB_33DD);
    idle(4);

    // Last accept went to req0, so the pointer now prefers req1.
    grant_log.delete();
    fork
      begin
        for (int k = 0; k < 4; k++) xfer(0, 9'h1A5, 32'h0, 4'h0, 32'hDEAD_BEEF);
      end
      begin
        for (int k = 0; k < 4; k++) xfer(1, 9'h0A5, 32'h0, 4'h0, 32'h11BB_33DD);
      end
    join
    idle(4);
    check("alt_count", grant_log.size(), 32'd8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
      check("alt_grant", grant_log[i], (i % 2 == 0) ? 32'd1 : 32'd0);
    end

    for (int i = 0; i < 4; i++) xfer(1, AW'(i), pat[i], 4'hF, 32'h0);
    acc_log.delete();
    for (int i = 0; i < 4; i++) xfer(1, AW'(i), 32'h0, 4'h0, pat[i]);
    idle(4);
    check("pipe_count", acc_log.size(), 32'd4);
    for (int i = 0; i + 1 < acc_log.size(); i++) begin
      check("pipe_gap", acc_log[i+1] - acc_log[i], 32'd1);
    end

    xfer(0, 9'h1A5, 32'h0, 4'h0, 32'hDEAD_BEEF);
    xfer(0, 9'h0A5, 32'h0, 4'h0, 32'h11BB_33DD);
    resetn = 0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due > cyc) sb.delete(i);
    end
    v0 = 1; a0 = 9'h0A5; s0 = '0;
    v1 = 1; a1 = 9'h001; s1 = '0;
    @(negedge clk);
    check("rst_ready", {30'b0, bus.req_ready}, 32'd0);
    repeat (2) begin
      @(negedge clk);
      check("rst_ready", {30'b0, bus.req_ready}, 32'd0);
      check("rst_cen", {31'b0, sram_cen}, 32'd1);
      check("rst_rsp", {30'b0, bus.rsp_valid}, 32'd0);
    end
    @(posedge clk);
    #1 resetn = 1;
    grant_log.delete();
    fork
      xfer(0, 9'h0A5, 32'h0, 4'h0, 32'h11BB_33DD);
      xfer(1, 9'h001, 32'h0, 4'h0, pat[1]);
    join
    idle(5);
    check("post_rst_count", grant_log.size(), 32'd2);
    if (grant_log.size() == 2) begin
      check("post_rst_first", grant_log[0], 32'd0);
      check("post_rst_second", grant_log[1], 32'd1);
    end
    check("sb_drained", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
